pixel_readout_ctrl: RTL and testbench



---
 rtl/pixel_readout_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : pixel_readout_ctrl
// Function : Frame sequencer for the pixel array: erase, expose, ramp-counter
//            conversion on the shared pixData buses, then row readout streamed
//            over valid/ready. Build option PIXEL_GRAY_CODE_EN: Gray-coded bus.
// Revision : 1.0
// =============================================================================
module pixel_readout_ctrl #(
    parameter int C_ERASE  = 5,
    parameter int C_EXPOSE = 255,
    parameter int C_SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       ERASE,
    output logic       RESET,
    output logic       EXPOSE,
    output logic       CONVERT,
    output logic       READ1,
    output logic       READ2,
    inout  wire  [7:0] pixData1,
    inout  wire  [7:0] pixData2,
    inout  wire  [7:0] pixData3,
    inout  wire  [7:0] pixData4,
    output logic [7:0] data_o,
    output logic [1:0] idx_o,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_done
);

    localparam logic [15:0] c_erase_last  = 16'(C_ERASE - 1);
    localparam logic [15:0] c_expose_last = 16'(C_EXPOSE - 1);
    localparam logic [15:0] c_settle_last = 16'(C_SETTLE - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ERASE   = 4'd1,
        S_EXPOSE  = 4'd2,
        S_CONVERT = 4'd3,
        S_GAP     = 4'd4,
        S_RD1     = 4'd5,
        S_OUT1    = 4'd6,
        S_RD2     = 4'd7,
        S_OUT2    = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_timer;
    logic [7:0]  r_count;
    logic [7:0]  r_cap0;
    logic [7:0]  r_cap1;
    logic        r_sel;
    logic        r_done;
    logic        w_xfer;
    logic        w_drive;
    logic [7:0]  w_bus;
    logic [7:0]  w_raw_a;
    logic [7:0]  w_raw_b;
    logic [7:0]  w_bin_a;
    logic [7:0]  w_bin_b;

`ifdef PIXEL_GRAY_CODE_EN
    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_bus   = r_count ^ (r_count >> 1);
    assign w_bin_a = gray2bin(w_raw_a);
    assign w_bin_b = gray2bin(w_raw_b);
`else
    assign w_bus   = r_count;
    assign w_bin_a = w_raw_a;
    assign w_bin_b = w_raw_b;
`endif

    // The buses are only ever driven inside the ramp window; the state after
    // CONVERT (S_GAP) is the turnaround cycle before any READx rises.
    assign w_drive  = (r_state == S_CONVERT);
    assign pixData1 = w_drive ? w_bus : 8'bz;
    assign pixData2 = w_drive ? w_bus : 8'bz;
    assign pixData3 = w_drive ? w_bus : 8'bz;
    assign pixData4 = w_drive ? w_bus : 8'bz;

    assign w_raw_a = (r_state == S_RD2) ? pixData3 : pixData1;
    assign w_raw_b = (r_state == S_RD2) ? pixData4 : pixData2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        ERASE      = 1'b0;
        RESET      = 1'b0;
        EXPOSE     = 1'b0;
        CONVERT    = 1'b0;
        READ1      = 1'b0;
        READ2      = 1'b0;
        data_valid = 1'b0;
        busy       = (r_state != S_IDLE);
        frame_done = r_done;
        case (r_state)
            S_IDLE: begin
                // start coinciding with frame_done is deliberately ignored
                if (start && !r_done) w_next = S_ERASE;
            end
            S_ERASE: begin
                ERASE = 1'b1;
                RESET = 1'b1;
                if (r_timer == c_erase_last) w_next = S_EXPOSE;
            end
            S_EXPOSE: begin
                EXPOSE = 1'b1;
                if (r_timer == c_expose_last) w_next = S_CONVERT;
            end
            S_CONVERT: begin
                CONVERT = 1'b1;
                if (r_count == 8'hFF) w_next = S_GAP;
            end
            S_GAP: begin
                w_next = S_RD1;
            end
            S_RD1: begin
                READ1 = 1'b1;
                if (r_timer == c_settle_last) w_next = S_OUT1;
            end
            S_OUT1: begin
                data_valid = 1'b1;
                if (data_ready && r_sel) w_next = S_RD2;
            end
            S_RD2: begin
                READ2 = 1'b1;
                if (r_timer == c_settle_last) w_next = S_OUT2;
            end
            S_OUT2: begin
                data_valid = 1'b1;
                if (data_ready && r_sel) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_xfer = data_valid && data_ready;
    assign data_o = data_valid ? (r_sel ? r_cap1 : r_cap0) : 8'd0;
    assign idx_o  = data_valid ? {(r_state == S_OUT2), r_sel} : 2'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 16'd0;
            r_count <= 8'd0;
            r_cap0  <= 8'd0;
            r_cap1  <= 8'd0;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_timer <= (w_next != r_state) ? 16'd0 : r_timer + 16'd1;
            // Reaches 255 on the last ramp cycle and returns to 0 as CONVERT ends
            r_count <= (r_state == S_CONVERT) ? r_count + 8'd1 : 8'd0;
            if ((r_state == S_RD1 || r_state == S_RD2) && w_next != r_state) begin
                r_cap0 <= w_bin_a;
                r_cap1 <= w_bin_b;
            end
            if (w_xfer) begin
                r_sel <= ~r_sel;
            end
            r_done <= (r_state == S_OUT2) && w_xfer && r_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_pixel_readout_ctrl
// Function : Self-checking bench for pixel_readout_ctrl with behavioural pixel
//            models and a cycle-timeline reference of the frame sequence.
// Revision : 1.0
// =============================================================================
module tb_pixel_readout_ctrl;

    localparam int CE = 5;
    localparam int CX = 255;
    localparam int CS = 1;
    localparam int CONV_FIRST = CE + CX + 1;
    localparam int GAP_CYC    = CE + CX + 257;
    localparam int FIRST_VAL  = 1 + CE + CX + 256 + 1 + CS;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       data_ready;
    logic       busy, ERASE, RESET, EXPOSE, CONVERT, READ1, READ2;
    logic [7:0] data_o;
    logic [1:0] idx_o;
    logic       data_valid, frame_done;
    wire  [7:0] pd1, pd2, pd3, pd4;

    logic [7:0] t   [4];
    logic [7:0] lat [4];
    int         conv_idx = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    // Pixel rows drive their latched words while selected; otherwise the bench
    // holds a sentinel so that any stray drive from the controller shows up.
    assign pd1 = CONVERT ? 8'bz : (READ1 ? lat[0] : 8'hA5);
    assign pd2 = CONVERT ? 8'bz : (READ1 ? lat[1] : 8'hA5);
    assign pd3 = CONVERT ? 8'bz : (READ2 ? lat[2] : 8'hA5);
    assign pd4 = CONVERT ? 8'bz : (READ2 ? lat[3] : 8'hA5);

    pixel_readout_ctrl #(.C_ERASE(CE), .C_EXPOSE(CX), .C_SETTLE(CS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .ERASE      (ERASE),
        .RESET      (RESET),
        .EXPOSE     (EXPOSE),
        .CONVERT    (CONVERT),
        .READ1      (READ1),
        .READ2      (READ2),
        .pixData1   (pd1),
        .pixData2   (pd2),
        .pixData3   (pd3),
        .pixData4   (pd4),
        .data_o     (data_o),
        .idx_o      (idx_o),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int v);
        logic [7:0] b;
        b = v[7:0];
`ifdef PIXEL_GRAY_CODE_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Advance one cycle and check the per-cycle bus and strobe invariants.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        check("strobe_excl", ($countones({ERASE, EXPOSE, CONVERT, READ1, READ2}) <= 1), 1);
        check("reset_eq_erase", RESET, ERASE);
        if (CONVERT) begin
            e = enc(conv_idx);
            check("bus1_ramp", pd1, e);
            check("bus2_ramp", pd2, e);
            check("bus3_ramp", pd3, e);
            check("bus4_ramp", pd4, e);
            for (int k = 0; k < 4; k++) begin
                if (conv_idx == int'(t[k])) lat[k] = pd1;
            end
            conv_idx++;
        end else begin
            conv_idx = 0;
            check("bus1_own", pd1, READ1 ? lat[0] : 8'hA5);
            check("bus2_own", pd2, READ1 ? lat[1] : 8'hA5);
            check("bus3_own", pd3, READ2 ? lat[2] : 8'hA5);
            check("bus4_own", pd4, READ2 ? lat[3] : 8'hA5);
        end
    endtask

    function automatic logic [18:0] outs();
        return {busy, ERASE, RESET, EXPOSE, CONVERT, READ1, READ2,
                data_valid, frame_done, idx_o, data_o};
    endfunction

    // mode: 0 = always ready, 1 = 10-cycle stall at idx 1, 2 = random ready
    task automatic run_frame(input int mode, input bit abort_mid, input bit extra_starts);
        int  k;
        int  stall;
        int  nout;
        bit  rdy;
        bit  xfer;
        bit  e_er, e_ex, e_cv, e_r1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < FIRST_VAL; c++) begin
            e_er = (c <= CE);
            e_ex = (c > CE) && (c <= CE + CX);
            e_cv = (c >= CONV_FIRST) && (c < GAP_CYC);
            e_r1 = (c > GAP_CYC) && (c <= GAP_CYC + CS);
            check("phase", {busy, ERASE, EXPOSE, CONVERT, READ1, READ2, data_valid, frame_done},
                  {1'b1, e_er, e_ex, e_cv, e_r1, 1'b0, 1'b0, 1'b0});
            if (abort_mid && c == CONV_FIRST + 8'h80) begin
                check("abort_bus_at_80", pd1, enc(8'h80));
                reset = 1'b1;
                step();
                reset = 1'b0;
                check("abort_outs_zero", outs(), 19'd0);
                return;
            end
            start = (extra_starts && c == CE + 20);
            data_ready = $urandom_range(0, 1);
            step();
            start = 1'b0;
        end
        check("first_valid", {data_valid, idx_o}, 3'b100);
        k = 0;
        stall = 0;
        nout = 0;
        while (k < 4 && nout < 300) begin
            check("no_early_done", frame_done, 0);
            if (data_valid) begin
                check("word_data", data_o, t[k]);
                check("word_idx", idx_o, k);
                check("no_read_in_out", READ1 | READ2, 0);
            end else begin
                check("rd2_window", {READ1, READ2}, {1'b0, (k == 2)});
            end
            if (mode == 1 && k == 1 && data_valid && stall < 10) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 2) begin
                rdy = $urandom_range(0, 1);
            end else begin
                rdy = 1'b1;
            end
            data_ready = rdy;
            xfer = data_valid && rdy;
            step();
            nout++;
            if (xfer) k++;
        end
        check("all_words", k, 4);
        if (mode == 0) check("out_cycles", nout, 4 + CS);
        if (mode == 1) check("out_cycles_stall", nout, 4 + CS + 10);
        check("done_pulse", {frame_done, busy}, 2'b10);
        start = extra_starts;
        data_ready = $urandom_range(0, 1);
        step();
        start = 1'b0;
        check("done_single", {frame_done, busy, ERASE}, 3'b000);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            t[k]   = 8'h00;
            lat[k] = 8'h00;
        end
        repeat (3) step();
        check("reset_outs", outs(), 19'd0);
        reset = 1'b0;
        step();
        check("idle_outs", outs(), 19'd0);

        t[0] = 8'h37; t[1] = 8'h10; t[2] = 8'hA4; t[3] = 8'hFF;
        run_frame(0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) t[k] = 8'($urandom);
        run_frame(1, 1'b0, 1'b1);

        run_frame(0, 1'b1, 1'b0);
        step();
        check("post_abort_idle", outs(), 19'd0);

        for (int k = 0; k < 4; k++) t[k] = 8'($urandom);
        run_frame(0, 1'b0, 1'b0);

        repeat (2) begin
            for (int k = 0; k < 4; k++) t[k] = 8'($urandom);
            run_frame(2, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
